display_scan: RTL

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 121 ++++++++++++
 1 files changed

// File: rtl/display_scan.sv
// Multiplexed scanner for a six-digit BCD clock display: one anode per slot,
// anti-ghost blanking at each slot start, per-frame digit snapshot and blinking.
module display_scan #(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic                      blink_tick,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] snapshot;
    logic                    blink_phase;
    logic                    blink_active;
    logic                    reload;

    logic                    slot_end;
    logic                    frame_end;
    logic [3:0]              cur_digit;
    logic                    cur_mask;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = 7'h3F;
        endcase
        return pattern;
    endfunction

    assign slot_end  = (presc == PRESC_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // On the first cycle after reset the snapshot is still being loaded, so the
    // live inputs stand in for it; otherwise only the frozen frame is shown.
    always_comb begin
        cur_digit = 4'd0;
        cur_mask  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_digit = reload ? digits[4*i +: 4] : snapshot[4*i +: 4];
                cur_mask  = blink_mask[i];
            end
        end
    end

    always_comb begin
        seg_next = 7'h7F;
        an_next  = '1;
        if (int'(presc) >= BLANK_CYC) begin
            seg_next = seg_decode(cur_digit);
            if (!(blink_active && cur_mask)) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx == IW'(i)) begin
                        an_next[i] = 1'b0;
                    end
                end
            end
        end
    end

    // The blink phase toggles immediately, but a slot only picks it up when it
    // starts, so a slot is either fully lit or fully dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc        <= '0;
            idx          <= '0;
            snapshot     <= '0;
            blink_phase  <= 1'b0;
            blink_active <= 1'b0;
            reload       <= 1'b1;
            seg          <= 7'h7F;
            an           <= '1;
            frame_done   <= 1'b0;
        end else begin
            reload      <= 1'b0;
            blink_phase <= blink_phase ^ blink_tick;

            if (slot_end) begin
                presc        <= '0;
                idx          <= frame_end ? '0 : idx + IW'(1);
                blink_active <= blink_phase ^ blink_tick;
            end else begin
                presc <= presc + PW'(1);
            end

            if (reload || frame_end) begin
                snapshot <= digits;
            end

            seg        <= seg_next;
            an         <= an_next;
            frame_done <= frame_end;
        end
    end

endmodule
